// File: rtl/spi_btn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_btn_pkg : shared state type and parameter defaults for spi_btn_reader
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_btn_pkg;

  localparam int unsigned C_CLK_DIV_DEF   = 4;
  localparam int unsigned C_BITS_DEF      = 8;
  localparam int unsigned C_POLL_BITS_DEF = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_sclk_gen : half-period counter producing SCLK toggle and sample strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int unsigned C_clk_div = 4
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_sclk_hi,
  output logic o_toggle,
  output logic o_sample
);

  localparam int unsigned c_cnt_w = $clog2(C_clk_div);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               w_last;

  always_comb begin
    w_last = (cnt_q == c_cnt_w'(C_clk_div - 1));
    cnt_d  = cnt_q;
    if (!i_en) begin
      cnt_d = '0;
    end else if (w_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A phase ending while SCLK is high is the falling edge, where MISO is taken.
  assign o_toggle = i_en && w_last;
  assign o_sample = o_toggle && i_sclk_hi;

endmodule
`default_nettype wire

// File: rtl/spi_btn_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_btn_reader : SPI master reading one button word per start or poll tick.
// Define SPI_BTN_READER_IRQ_EN to enable the data-change irq pulse. Rev 1.0
// ----------------------------------------------------------------------------
module spi_btn_reader
  import spi_btn_pkg::*;
#(
  parameter int unsigned C_clk_div   = C_CLK_DIV_DEF,
  parameter int unsigned C_bits      = C_BITS_DEF,
  parameter int unsigned C_poll_bits = C_POLL_BITS_DEF
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              start,
  input  logic              poll_en,
  output logic              spi_csn,
  output logic              spi_sclk,
  input  logic              spi_miso,
  output logic [C_bits-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              irq
);

  localparam int unsigned c_bcnt_w = $clog2(C_bits + 1);

  spi_state_e             state_q, state_d;
  logic                   go_q, go_d;
  logic                   busy_q, busy_d;
  logic                   csn_q, csn_d;
  logic                   sclk_q, sclk_d;
  logic                   valid_q, valid_d;
  logic [C_bits-1:0]      data_q, data_d;
  logic [C_bits-1:0]      shreg_q, shreg_d;
  logic [c_bcnt_w-1:0]    bit_cnt_q, bit_cnt_d;
  logic [C_poll_bits-1:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]             sync_q, sync_d;

  logic w_gen_en;
  logic w_toggle;
  logic w_sample;
  logic w_poll_tick;

  assign w_gen_en = (state_q != IDLE);

  spi_sclk_gen #(
    .C_clk_div (C_clk_div)
  ) u_sclk_gen (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .i_en      (w_gen_en),
    .i_sclk_hi (sclk_q),
    .o_toggle  (w_toggle),
    .o_sample  (w_sample)
  );

  always_comb begin
    sync_d      = {sync_q[0], spi_miso};
    poll_cnt_d  = poll_en ? poll_cnt_q + 1'b1 : '0;
    w_poll_tick = poll_en && (poll_cnt_q == '1);
  end

  always_comb begin
    state_d   = state_q;
    go_d      = 1'b0;
    busy_d    = busy_q;
    csn_d     = csn_q;
    sclk_d    = sclk_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      IDLE: begin
        // The request is latched for one cycle so busy rises before csn falls.
        if (go_q) begin
          state_d   = SETUP;
          csn_d     = 1'b0;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else if (start || w_poll_tick) begin
          go_d   = 1'b1;
          busy_d = 1'b1;
        end
      end

      SETUP: begin
        if (w_toggle) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (w_sample) begin
          shreg_d   = {shreg_q[C_bits-2:0], sync_q[1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (w_toggle) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == c_bcnt_w'(C_bits)) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (w_toggle) begin
          state_d = IDLE;
          csn_d   = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          data_d  = shreg_q;
        end
      end

      default: begin
        state_d = IDLE;
        csn_d   = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      csn_q      <= 1'b1;
      sclk_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      poll_cnt_q <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      csn_q      <= csn_d;
      sclk_q     <= sclk_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      sync_q     <= sync_d;
    end
  end

`ifdef SPI_BTN_READER_IRQ_EN
  logic irq_q, irq_d;

  // data_q still holds the previous word on the edge that loads the new one.
  always_comb begin
    irq_d = (state_q == HOLD) && w_toggle && (shreg_q != data_q);
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign spi_csn  = csn_q;
  assign spi_sclk = sclk_q;
  assign data     = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_btn_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_btn_reader : scoreboard bench; instance 0 uses defaults, instance 1
// uses C_clk_div=3 / C_poll_bits=6. Honours SPI_BTN_READER_IRQ_EN. Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_btn_reader;

`ifdef SPI_BTN_READER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] word;
    longint     vcyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] poll_en;
  logic [1:0] miso = 2'b00;
  logic [1:0] csn, sclk, valid, busy, irq;
  logic [7:0] data [2];

  longint cyc = 0;
  int     n_pass = 0;
  int     n_fail = 0;

  bit         active [2];
  longint     s_edge [2];
  int         pcnt   [2];
  logic [7:0] data_exp [2];
  logic [7:0] dir_q [2][$];
  logic [7:0] tx_q  [2][$];
  exp_t       exp_q [2][$];

  spi_btn_reader u_dut0 (
    .clk_25mhz (clk), .rst_n (rst_n), .start (start[0]), .poll_en (poll_en[0]),
    .spi_csn (csn[0]), .spi_sclk (sclk[0]), .spi_miso (miso[0]),
    .data (data[0]), .valid (valid[0]), .busy (busy[0]), .irq (irq[0])
  );

  spi_btn_reader #(.C_clk_div(3), .C_bits(8), .C_poll_bits(6)) u_dut1 (
    .clk_25mhz (clk), .rst_n (rst_n), .start (start[1]), .poll_en (poll_en[1]),
    .spi_csn (csn[1]), .spi_sclk (sclk[1]), .spi_miso (miso[1]),
    .data (data[1]), .valid (valid[1]), .busy (busy[1]), .irq (irq[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int g);
    return (g == 0) ? 4 : 3;
  endfunction

  function automatic int pmax(input int g);
    return (g == 0) ? ((1 << 17) - 1) : 63;
  endfunction

  // Cycles from the start-sampling edge to the valid edge.
  function automatic longint lat(input int g);
    return longint'((2 * 8 + 2) * div_of(g) + 1);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs at a negedge and advance the reference model.
  task automatic step(input logic [1:0] st, input logic [1:0] pe);
    start   = st;
    poll_en = pe;
    for (int g = 0; g < 2; g++) begin
      logic       req;
      logic [7:0] w;
      exp_t       e;
      req     = st[g] || (pe[g] && (pcnt[g] == pmax(g)));
      pcnt[g] = pe[g] ? ((pcnt[g] == pmax(g)) ? 0 : pcnt[g] + 1) : 0;
      if (req && (!active[g] || (cyc + 1 > s_edge[g] + lat(g)))) begin
        active[g] = 1'b1;
        s_edge[g] = cyc + 1;
        if (dir_q[g].size() > 0) w = dir_q[g].pop_front();
        else w = 8'($urandom_range(0, 255));
        tx_q[g].push_back(w);
        e.word = w;
        e.vcyc = s_edge[g] + lat(g);
        exp_q[g].push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("reset_async_csn_sclk", {csn[0], sclk[0]}, 2'b10);
    for (int g = 0; g < 2; g++) begin
      active[g]   = 1'b0;
      pcnt[g]     = 0;
      data_exp[g] = 8'h00;
      exp_q[g].delete();
      tx_q[g].delete();
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Responder: MISO moves most of a cycle after SCLK rises, MSB first.
  logic [7:0] rsh  [2];
  int         ridx [2];
  logic [1:0] csn_prev  = 2'b11;
  logic [1:0] sclk_prev = 2'b00;
  logic [1:0] rise;
  always @(posedge clk) begin
    #2;
    for (int g = 0; g < 2; g++) begin
      if (!csn[g] && csn_prev[g]) begin
        rsh[g]  = (tx_q[g].size() > 0) ? tx_q[g].pop_front() : 8'h00;
        ridx[g] = 0;
      end
      rise[g]      = !csn[g] && sclk[g] && !sclk_prev[g];
      csn_prev[g]  = csn[g];
      sclk_prev[g] = sclk[g];
    end
    #5;
    for (int g = 0; g < 2; g++) begin
      if (rise[g] && ridx[g] < 8) begin
        miso[g] = rsh[g][7 - ridx[g]];
        ridx[g] = ridx[g] + 1;
      end
    end
  end

  bit     m_b, m_c, m_s;
  longint m_o;
  exp_t   m_e;
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        chk($sformatf("reset_outputs[%0d]", g), {csn[g], sclk[g], valid[g], busy[g], irq[g]}, 5'b10000);
        chk($sformatf("reset_data[%0d]", g), data[g], 0);
      end else begin
        m_b = active[g] && (cyc >= s_edge[g]) && (cyc < s_edge[g] + lat(g));
        m_c = active[g] && (cyc >= s_edge[g] + 1) && (cyc < s_edge[g] + lat(g));
        m_o = cyc - s_edge[g] - 1;
        m_s = m_c && (m_o / div_of(g) >= 1) && (m_o / div_of(g) <= 16) && ((m_o / div_of(g)) % 2 == 1);
        chk($sformatf("busy_csn_sclk[%0d]", g), {busy[g], csn[g], sclk[g]}, {m_b, !m_c, m_s});
        if (exp_q[g].size() > 0 && cyc == exp_q[g][0].vcyc) begin
          m_e = exp_q[g].pop_front();
          chk($sformatf("valid_at_latency[%0d]", g), valid[g], 1);
          chk($sformatf("data[%0d]", g), data[g], m_e.word);
          chk($sformatf("irq_on_valid[%0d]", g), irq[g], IRQ_ON && (m_e.word != data_exp[g]));
          data_exp[g] = m_e.word;
        end else begin
          chk($sformatf("no_valid[%0d]", g), valid[g], 0);
          chk($sformatf("data_hold[%0d]", g), data[g], data_exp[g]);
          chk($sformatf("irq_quiet[%0d]", g), irq[g], 0);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    start   = 2'b00;
    poll_en = 2'b00;
    for (int g = 0; g < 2; g++) begin
      active[g]   = 1'b0;
      s_edge[g]   = 0;
      pcnt[g]     = 0;
      data_exp[g] = 8'h00;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a transfer, while SCLK is high.
    dir_q[0].push_back(8'h3C);
    step(2'b01, 2'b00);
    repeat (29) step(2'b00, 2'b00);
    do_reset();

    // Single transfer of 0xA5.
    dir_q[0].push_back(8'hA5);
    step(2'b01, 2'b00);
    repeat (80) step(2'b00, 2'b00);

    // Restarts while busy, on the valid edge, and on the cycle after valid.
    for (int i = 0; i < 160; i++) begin
      step({1'b0, (i == 0) || (i == 10) || (i == 40) || (i == 73) || (i == 74)}, 2'b00);
    end

    // Random start pulses on both instances with random words.
    repeat (1500) begin
      logic [1:0] st;
      st[0] = ($urandom_range(0, 7) == 0);
      st[1] = ($urandom_range(0, 7) == 0);
      step(st, 2'b00);
    end
    repeat (80) step(2'b00, 2'b00);

    // Change detection starting from a fresh reset: 0x00, 0x00, 0x01.
    do_reset();
    dir_q[0].push_back(8'h00);
    dir_q[0].push_back(8'h00);
    dir_q[0].push_back(8'h01);
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 2'b00);
      repeat (79) step(2'b00, 2'b00);
    end

    // Auto-poll on the short-period instance.
    repeat (300) step(2'b00, 2'b10);
    repeat (100) step(2'b00, 2'b00);

    for (int g = 0; g < 2; g++) begin
      chk($sformatf("pending_transfers[%0d]", g), exp_q[g].size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
`default_nettype wire
